// File: rtl/cpu_defs.sv
// Shared CPU-wide types and constants used by the EX-stage execution units.
package cpu_defs;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] Word_t;
   typedef logic            Bit_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } DivState_t;

   // Architectural result for a zero divisor: quotient saturates to all ones.
   localparam Word_t DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 division iteration, purely combinational.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic           fits;

   // Extra top bit keeps the compare exact; the restored remainder is always
   // below the divisor, so the low WIDTH bits of the difference are sufficient.
   assign shifted = {rem_in, quo_in[WIDTH-1]};
   assign fits    = shifted >= {1'b0, divisor};
   assign rem_out = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
   assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the EX stage (DIV/DIVU -> LO/HI).
//   state | meaning
//   IDLE  | waiting for start; operands sampled on start
//   BUSY  | one restoring step per cycle, WIDTH steps total
//   DONE  | results valid; held while EX is stalled downstream
module div_unit
   import cpu_defs::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             ex_stall,
   input  logic             flush,
   output logic             stall_req,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   DivState_t        state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   Bit_t             q_neg, r_neg;
   logic             dvs_zero;

   assign dvd_abs  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
   assign dvs_zero = (divisor == '0);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .divisor (dvs),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = dvs_zero ? DONE : BUSY;
         BUSY:    if (count == LAST_STEP) state_nxt = DONE;
         DONE:    if (!ex_stall) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   assign stall_req    = ((state == IDLE && start) || state == BUSY) && !flush;
   assign result_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (start) begin
                  rem   <= '0;
                  quo   <= dvd_abs;
                  dvs   <= dvs_abs;
                  count <= '0;
                  q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg <= is_signed & dividend[WIDTH-1];
                  // Zero divisor skips iteration; remainder is the raw dividend.
                  if (dvs_zero) begin
                     quotient  <= WIDTH'(DIV_ZERO_QUOT);
                     remainder <= dividend;
                  end
               end
            end
            BUSY: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               if (count == LAST_STEP) begin
                  quotient  <= q_neg ? -quo_nxt : quo_nxt;
                  remainder <= r_neg ? -rem_nxt : rem_nxt;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signs, zero divisor, stall, flush, reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, is_signed, ex_stall, flush;
   logic [31:0] dividend, divisor;
   logic        stall_req, result_valid;
   logic [31:0] quotient, remainder;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .is_signed    (is_signed),
      .dividend     (dividend),
      .divisor      (divisor),
      .ex_stall     (ex_stall),
      .flush        (flush),
      .stall_req    (stall_req),
      .result_valid (result_valid),
      .quotient     (quotient),
      .remainder    (remainder)
   );

   // Drives a divide just after a falling edge and counts stall_req cycles.
   // skip=1 when called while the previous divide still sits in DONE.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input bit skip, output int n);
      n         = 0;
      start     = 1'b1;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      if (skip) @(negedge clk);
      #1;
      while (stall_req === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; ex_stall = 1'b0; flush = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (stall_req !== 1'b0 || result_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
         failures++;
         $display("FAIL reset: stall=%b valid=%b q=%h r=%h, required 0 0 0 0",
                  stall_req, result_valid, quotient, remainder);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int n;
      do_div(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, n);
      checks++;
      if (n !== 33) begin failures++; $display("FAIL divu_latency: got %0d required 33", n); end
      checks++;
      if (result_valid !== 1'b1) begin failures++; $display("FAIL divu_valid: got %b required 1", result_valid); end
      checks++;
      if (quotient !== 32'h0FFF_FFFF) begin failures++; $display("FAIL divu_q: got %h required 0fffffff", quotient); end
      checks++;
      if (remainder !== 32'hF) begin failures++; $display("FAIL divu_r: got %h required 0000000f", remainder); end
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (result_valid !== 1'b0 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL divu_idle: valid=%b stall=%b required 0 0", result_valid, stall_req);
      end
   endtask

   task automatic test_signed();
      logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
      logic [31:0] vb [3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
      logic [31:0] er [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      int n;
      for (int i = 0; i < 3; i++) begin
         do_div(va[i], vb[i], 1'b1, 1'b0, n);
         checks++;
         if (result_valid !== 1'b1 || quotient !== eq[i] || remainder !== er[i] || n !== 33) begin
            failures++;
            $display("FAIL div_signed[%0d]: valid=%b q=%h r=%h cyc=%0d, required 1 %h %h 33",
                     i, result_valid, quotient, remainder, n, eq[i], er[i]);
         end
         start = 1'b0;
         @(negedge clk); #1;
      end
   endtask

   task automatic test_div_zero();
      int n;
      do_div(32'h1234, 32'h0, 1'b0, 1'b0, n);
      checks++;
      if (n !== 1) begin failures++; $display("FAIL divzero_latency: got %0d required 1", n); end
      checks++;
      if (result_valid !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234) begin
         failures++;
         $display("FAIL divzero_result: valid=%b q=%h r=%h, required 1 ffffffff 00001234",
                  result_valid, quotient, remainder);
      end
      start = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_ex_stall();
      int n;
      do_div(32'd100, 32'd7, 1'b0, 1'b0, n);
      ex_stall = 1'b1;
      checks++;
      if (n !== 33 || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_entry: cyc=%0d valid=%b, required 33 1", n, result_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (result_valid !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2 || stall_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold[%0d]: valid=%b q=%0d r=%0d stall=%b, required 1 14 2 0",
                     i, result_valid, quotient, remainder, stall_req);
         end
      end
      ex_stall = 1'b0;
      start    = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (result_valid !== 1'b0) begin failures++; $display("FAIL stall_release: valid=%b required 0", result_valid); end
   endtask

   task automatic test_flush();
      int n;
      start = 1'b1; is_signed = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd5;
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if (stall_req !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b required 0", stall_req); end
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if (result_valid !== 1'b0 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle: valid=%b stall=%b required 0 0", result_valid, stall_req);
      end
      do_div(32'd9, 32'd3, 1'b0, 1'b0, n);
      checks++;
      if (n !== 33 || result_valid !== 1'b1 || quotient !== 32'd3 || remainder !== 32'd0) begin
         failures++;
         $display("FAIL flush_restart: cyc=%0d valid=%b q=%0d r=%0d, required 33 1 3 0",
                  n, result_valid, quotient, remainder);
      end
      start = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n;
      do_div(32'd10, 32'd3, 1'b0, 1'b0, n);
      checks++;
      if (n !== 33 || result_valid !== 1'b1 || quotient !== 32'd3 || remainder !== 32'd1) begin
         failures++;
         $display("FAIL b2b_first: cyc=%0d valid=%b q=%0d r=%0d, required 33 1 3 1",
                  n, result_valid, quotient, remainder);
      end
      do_div(32'd20, 32'd6, 1'b0, 1'b1, n);
      checks++;
      if (n !== 33 || result_valid !== 1'b1 || quotient !== 32'd3 || remainder !== 32'd2) begin
         failures++;
         $display("FAIL b2b_second: cyc=%0d valid=%b q=%0d r=%0d, required 33 1 3 2",
                  n, result_valid, quotient, remainder);
      end
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (result_valid !== 1'b0 || stall_req !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: valid=%b stall=%b required 0 0", result_valid, stall_req);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; is_signed = 1'b0; dividend = 32'd10; divisor = 32'd3;
      repeat (5) @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (stall_req !== 1'b0 || result_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid: stall=%b valid=%b q=%h r=%h, required 0 0 0 0",
                  stall_req, result_valid, quotient, remainder);
      end
      rst = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ex_stall();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle 32-bit integer divider for the EX stage, serving DIV and DIVU.
- Sits upstream of the pipeline controller. Its stall_req drives the controller's EX stall request.
- Consumes the controller's EX-stall bit and flush.
- Delivers quotient (to LO) and remainder (to HI) back to EX.

Parameters:
WIDTH, 32, operand and result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  EX holds a DIV/DIVU; level signal, held for as long as the instruction sits in EX.
is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start in IDLE.
dividend  input  WIDTH  rs operand; sampled with start in IDLE.
divisor  input  WIDTH  rt operand; sampled with start in IDLE.
ex_stall  input  1  controller stall bit for the EX stage; 1 = the EX instruction does not advance this cycle.
flush  input  1  controller flush (exception); aborts any operation.
stall_req  output  1  to controller stall_from_ex; combinational.
result_valid  output  1  quotient/remainder are final for the EX instruction.
quotient  output  WIDTH  LO result.
remainder  output  WIDTH  HI result.

Behaviour:
- States: IDLE, BUSY, DONE. The DivState_t enum lives in the shared package.
- Reset: state=IDLE, count=0, all internal registers 0, quotient=0, remainder=0, result_valid=0, stall_req=0.
- stall_req = ((state==IDLE && start) || state==BUSY) && !flush.
  - It is 0 in DONE, so the instruction can leave EX.
- IDLE, start=1, flush=0:
  - Latch |dividend| and |divisor| (plain values when is_signed=0).
  - Latch q_neg = is_signed & (sign(dividend) ^ sign(divisor)) and r_neg = is_signed & sign(dividend).
  - Divisor == 0: go directly to DONE with quotient=all ones, remainder=dividend (raw). Total stall = 1 cycle.
  - Divisor != 0: go to BUSY, count=0.
- BUSY: one restoring radix-2 step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem >= divisor: rem -= divisor, quo[0]=1.
  - Partial remainder is WIDTH+1 bits, so no overflow occurs.
  - After the step with count==WIDTH-1, go to DONE. Otherwise count++.
- Entry into DONE: register quotient = q_neg ? -quo : quo and remainder = r_neg ? -rem : rem (two's complement, WIDTH bits, wrap).
- Latency: start cycle plus WIDTH BUSY cycles = 33 cycles with stall_req=1. result_valid=1 in the 34th cycle.
- DONE: result_valid=1.
  - ex_stall=0: go to IDLE next edge. The instruction retires from EX at this edge.
  - ex_stall=1 (downstream stall): hold DONE and the results unchanged. start stays high and is ignored.
- Back-to-back divides: the next start is seen in IDLE on the cycle after DONE exits.
- flush=1 in any state: state=IDLE and result_valid=0 on the next edge. stall_req=0 in the flush cycle. Flush has priority over start.
- rst mid-operation: same as the reset values above.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (wrap, no trap).
- quotient/remainder hold their last value outside DONE. They are meaningful only while result_valid=1.

Decomposition:
- Shared package (cpu_defs):
  - DivState_t enum {IDLE, BUSY, DONE}.
  - Word_t and Bit_t reused.
  - Localparam DIV_ZERO_QUOT = all ones.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
- State machine, sign handling and counter stay in div_unit.

Test Plan:
- Unsigned: DIVU 0xFFFFFFFF / 0x10, ex_stall=0.
  - stall_req=1 for exactly 33 cycles.
  - Then result_valid=1, quotient=0x0FFFFFFF, remainder=0xF.
  - IDLE next cycle.
- Signed: DIV -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Also 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
  - Also 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: DIVU 0x1234 / 0.
  - stall_req=1 for 1 cycle.
  - Then DONE with quotient=0xFFFFFFFF, remainder=0x1234.
- Downstream stall: 100/7 reaches DONE with ex_stall=1 for 3 cycles.
  - result_valid stays 1, quotient=14, remainder=2 stable, stall_req=0 throughout.
  - IDLE after ex_stall drops.
- Flush: flush=1 at BUSY count=10.
  - Next cycle: IDLE, stall_req=0, result_valid=0.
  - A new start then completes normally: 9/3 → quotient=3, remainder=0.
- Back-to-back and reset: two consecutive DIVUs, 10/3 then 20/6.
  - Both give quotient=3, remainder=1 (first) and quotient=3, remainder=2 (second).
  - rst asserted mid-BUSY → IDLE and all outputs 0 on the next edge.
